// File: rtl/key_scan_encoder.sv
// -----------------------------------------------------------------------------
// key_scan_encoder
//
// Debounced priority encoder for a bank of active-low key lines. The raw key
// lines are synchronized, the highest active index is taken as the key code,
// and a four-state FSM debounces both press and release. Each debounced press
// posts one event into a single-entry valid/ready register. An event that
// arrives while the register is still full is dropped, and the sticky
// overflow flag is set.
//
// Parameters
//   N_KEYS     number of key inputs (2..64)
//   DB_CYCLES  debounce length in clk cycles (2..65535)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   S_n        raw key lines, active-low, asynchronous to clk
//   evt_ready  consumer accepts the pending event
//   ovf_clr    synchronous clear of the overflow flag
//   L          code of the debounced held key, 0 when none held
//   GS         debounced key-held flag
//   evt_valid  press event pending
//   evt_code   code of the pending press event
//   ovf        sticky event-lost flag
// -----------------------------------------------------------------------------
module key_scan_encoder #(
    parameter int N_KEYS    = 10,
    parameter int DB_CYCLES = 16,
    localparam int CW       = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] S_n,
    input  logic              evt_ready,
    input  logic              ovf_clr,
    output logic [CW-1:0]     L,
    output logic              GS,
    output logic              evt_valid,
    output logic [CW-1:0]     evt_code,
    output logic              ovf
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer. Resets to all-ones so that the idle (released)
    // level is presented right after reset; a key still held through reset
    // is therefore seen as a fresh press and debounced again in full.
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] sync1_reg;
    logic [N_KEYS-1:0] sync2_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= S_n;
            sync2_reg <= sync1_reg;
        end
    end

    // Active-high key vector, built bit by bit from the synchronized lines.
    logic [N_KEYS-1:0] active;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_active
            assign active[gi] = ~sync2_reg[gi];
        end
    endgenerate

    // Priority encoder: the loop runs upward, so the highest active index
    // is the last one assigned and wins.
    logic [CW-1:0] enc_code;
    logic          key_any;

    always_comb begin
        enc_code = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (active[i]) begin
                enc_code = CW'(i);
            end
        end
    end

    assign key_any = |active;

    // ------------------------------------------------------------------
    // Debounce FSM: state register
    // ------------------------------------------------------------------
    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [CW-1:0]     cand_reg;
    logic [CW-1:0]     cand_next;
    logic              post_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cand_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM: next-state logic
    // The counter holds the number of consecutive stable cycles seen so far.
    // The transition fires on the edge where it would reach DB_CYCLES, so
    // the first stable sample (counter=1) is the first of the DB_CYCLES.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        post_evt   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (key_any) begin
                    cand_next  = enc_code;
                    cnt_next   = CNT_ONE;
                    state_next = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (!key_any) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (enc_code != cand_reg) begin
                    // Candidate moved: restart the stability window.
                    cand_next = enc_code;
                    cnt_next  = CNT_ONE;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next   = cnt_reg + CNT_ONE;
                    state_next = PRESSED;
                    post_evt   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            PRESSED: begin
                // Code changes while held are ignored; only release matters.
                if (!key_any) begin
                    cnt_next   = CNT_ONE;
                    state_next = RELEASE;
                end
            end

            RELEASE: begin
                if (key_any) begin
                    // Re-bounce: back to held, the press is not re-reported.
                    state_next = PRESSED;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Debounce FSM: outputs
    // Decoded from state so that reset clears them without waiting for an edge.
    // ------------------------------------------------------------------
    always_comb begin
        GS = 1'b0;
        L  = '0;
        if (state_reg == PRESSED || state_reg == RELEASE) begin
            GS = 1'b1;
            L  = cand_reg;
        end
    end

    // ------------------------------------------------------------------
    // Single-entry event register with sticky overflow
    // ------------------------------------------------------------------
    logic handshake;
    logic evt_lost;

    assign handshake = evt_valid && evt_ready;
    // A post can only be taken if the slot is empty or is being drained now.
    assign evt_lost  = post_evt && evt_valid && !evt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_code  <= '0;
        end else if (post_evt && !evt_lost) begin
            evt_valid <= 1'b1;
            evt_code  <= cand_reg;
        end else if (handshake) begin
            evt_valid <= 1'b0;
        end
    end

    // Overflow wins over a simultaneous clear so that a loss is never missed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (evt_lost) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_scan_encoder.sv
// -----------------------------------------------------------------------------
// tb_key_scan_encoder
//
// Bench for key_scan_encoder with N_KEYS=10, DB_CYCLES=4. Expected press
// events are queued when a press is driven. A monitor pops the queue whenever
// the DUT presents a new event. Timing-sensitive expectations (latency, GS/L,
// overflow) are checked directly, one tick after the relevant clock edge.
// -----------------------------------------------------------------------------
module tb_key_scan_encoder;

    localparam int N_KEYS    = 10;
    localparam int DB_CYCLES = 4;
    localparam int CW        = $clog2(N_KEYS);

    logic              clk;
    logic              rst;
    logic [N_KEYS-1:0] S_n;
    logic              evt_ready;
    logic              ovf_clr;
    logic [CW-1:0]     L;
    logic              GS;
    logic              evt_valid;
    logic [CW-1:0]     evt_code;
    logic              ovf;

    key_scan_encoder #(
        .N_KEYS    (N_KEYS),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .S_n       (S_n),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .L         (L),
        .GS        (GS),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", tag, obs, $time);
        end
    endtask

    // Advance one clock edge, then settle past it before sampling/driving.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_keys(input logic [N_KEYS-1:0] mask);
        S_n = ~mask;
    endtask

    // Scoreboard monitor: a new event is a rising evt_valid, or evt_valid
    // still high after an edge on which a handshake took place.
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;

    always @(negedge clk) begin
        if (evt_valid && (!prev_valid || prev_ready)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_evt", 1, 0);
            end else begin
                check("sb_evt_code", int'(evt_code), exp_q.pop_front());
            end
        end
        prev_valid = evt_valid;
        prev_ready = evt_ready;
    end

    initial begin
        rst       = 1'b1;
        S_n       = '1;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;

        // ---- reset state ----
        tick(2);
        check("rst_GS", int'(GS), 0);
        check("rst_L", int'(L), 0);
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_code", int'(evt_code), 0);
        check("rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        tick(3);
        check("idle_GS", int'(GS), 0);

        // ---- press and hold key 5, no consumer ----
        set_keys(10'(1 << 5));
        exp_q.push_back(5);
        tick(5);
        check("k5_valid_edge5", int'(evt_valid), 0);
        check("k5_GS_edge5", int'(GS), 0);
        tick(1);
        check("k5_valid_edge6", int'(evt_valid), 1);
        check("k5_code_edge6", int'(evt_code), 5);
        check("k5_GS_edge6", int'(GS), 1);
        check("k5_L_edge6", int'(L), 5);
        tick(3);
        check("k5_L_hold", int'(L), 5);
        // Release takes 2 sync edges + DB_CYCLES edges before GS falls.
        set_keys('0);
        tick(5);
        check("k5_rel_GS_edge5", int'(GS), 1);
        tick(1);
        check("k5_rel_GS_edge6", int'(GS), 0);
        check("k5_rel_L_edge6", int'(L), 0);
        evt_ready = 1'b1;
        tick(1);
        check("k5_handshake", int'(evt_valid), 0);
        tick(1);
        check("ready_idle_noeffect", int'(evt_valid), 0);
        evt_ready = 1'b0;

        // ---- glitch on key 5: two cycles low, then high ----
        set_keys(10'(1 << 5));
        tick(2);
        set_keys('0);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("glitch_GS", int'(GS), 0);
        end
        check("glitch_valid", int'(evt_valid), 0);

        // ---- keys 9 and 2 together, then drop 9 ----
        evt_ready = 1'b1;
        set_keys(10'((1 << 9) | (1 << 2)));
        exp_q.push_back(9);
        tick(6);
        check("k92_valid", int'(evt_valid), 1);
        check("k92_code", int'(evt_code), 9);
        tick(1);
        check("k92_drained", int'(evt_valid), 0);
        set_keys(10'(1 << 2));
        tick(8);
        check("k2_L_stays9", int'(L), 9);
        check("k2_GS", int'(GS), 1);
        check("k2_no_evt", int'(evt_valid), 0);
        set_keys('0);
        tick(8);
        check("k92_rel_GS", int'(GS), 0);

        // ---- key 3 with a re-bounce during release ----
        set_keys(10'(1 << 3));
        exp_q.push_back(3);
        tick(6);
        check("k3_GS", int'(GS), 1);
        set_keys('0);
        tick(2);
        set_keys(10'(1 << 3));
        tick(2);
        set_keys('0);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("k3_rebounce_GS", int'(GS), 1);
        end
        tick(1);
        check("k3_final_GS", int'(GS), 0);
        evt_ready = 1'b0;

        // ---- 7 then 1 with no consumer: overflow, clear collides ----
        set_keys(10'(1 << 7));
        exp_q.push_back(7);
        tick(6);
        check("k7_code", int'(evt_code), 7);
        set_keys('0);
        tick(8);
        set_keys(10'(1 << 1));
        tick(5);
        check("k1_ovf_before", int'(ovf), 0);
        ovf_clr = 1'b1;
        tick(1);
        check("k1_ovf_set", int'(ovf), 1);
        check("k1_code_kept", int'(evt_code), 7);
        check("k1_valid_kept", int'(evt_valid), 1);
        check("k1_L", int'(L), 1);
        tick(1);
        check("ovf_cleared", int'(ovf), 0);
        ovf_clr = 1'b0;
        set_keys('0);
        tick(8);

        // ---- new event lands on a handshake edge (key 0) ----
        set_keys(10'(1 << 0));
        exp_q.push_back(0);
        tick(5);
        evt_ready = 1'b1;
        tick(1);
        check("k0_valid", int'(evt_valid), 1);
        check("k0_code", int'(evt_code), 0);
        check("k0_ovf", int'(ovf), 0);
        check("k0_GS", int'(GS), 1);
        tick(1);
        check("k0_drained", int'(evt_valid), 0);
        set_keys('0);
        tick(8);

        // ---- reset while key 4 is held ----
        set_keys(10'(1 << 4));
        exp_q.push_back(4);
        tick(8);
        check("k4_GS", int'(GS), 1);
        rst = 1'b1;
        #1;
        check("k4_rst_GS", int'(GS), 0);
        check("k4_rst_L", int'(L), 0);
        check("k4_rst_valid", int'(evt_valid), 0);
        tick(1);
        rst = 1'b0;
        exp_q.push_back(4);
        tick(5);
        check("k4_re_valid_edge5", int'(evt_valid), 0);
        tick(1);
        check("k4_re_valid_edge6", int'(evt_valid), 1);
        check("k4_re_code", int'(evt_code), 4);
        tick(2);
        set_keys('0);
        tick(8);

        check("sb_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_scan_encoder.md
KEY_SCAN_ENCODER -- requirements
Module: key_scan_encoder

Interface
REQ-001 SHALL provide parameter N_KEYS, default 10: number of key inputs, legal range 2..64.
REQ-002 SHALL provide parameter DB_CYCLES, default 16: debounce length in clk cycles, legal range 2..65535.
REQ-003 SHALL derive localparam CW = $clog2(N_KEYS): code width.
REQ-004 SHALL provide clk  input  1  as the single clock; all state updates on its rising edge.
REQ-005 SHALL provide rst  input  1  as the reset: asynchronous, active-high.
REQ-006 SHALL provide S_n  input  N_KEYS  as the raw key lines: active-low, asynchronous to clk.
REQ-007 SHALL provide evt_ready  input  1  as the consumer accept for the event register.
REQ-008 SHALL provide ovf_clr  input  1  as the synchronous clear of the overflow flag.
REQ-009 SHALL provide L  output  CW  as the code of the debounced held key; 0 when none.
REQ-010 SHALL provide GS  output  1  as the debounced key-held flag.
REQ-011 SHALL provide evt_valid  output  1  as the press-event pending flag.
REQ-012 SHALL provide evt_code  output  CW  as the code of the pending press event.
REQ-013 SHALL provide ovf  output  1  as the sticky event-lost flag.

Function
REQ-014 SHALL pass S_n through a 2-flop synchronizer; all further logic SHALL use only the synchronized value.
REQ-015 SHALL form the active vector as the inverse of the synchronized S_n.
REQ-016 SHALL encode the active vector by priority: highest active index wins, and the code equals that index.
- Example: keys 9 and 3 both active -> code 9.
REQ-017 SHALL implement FSM states IDLE, DEBOUNCE, PRESSED and RELEASE, with IDLE as the reset state.
REQ-018 IDLE: any key active -> latch the candidate code, load the counter with 1, go to DEBOUNCE.
REQ-019 DEBOUNCE, same code still active -> increment the counter; on reaching DB_CYCLES, go to PRESSED and post an event with the candidate code.
REQ-020 DEBOUNCE, no key active -> go to IDLE, no event.
REQ-021 DEBOUNCE, a different code active -> latch the new candidate and reload the counter with 1; state stays DEBOUNCE.
REQ-022 PRESSED: GS=1 and L = the latched code; a change to a different non-zero code SHALL be ignored (no new event) until release.
REQ-023 PRESSED, no key active -> go to RELEASE and load the counter with 1.
REQ-024 RELEASE, no key active -> increment the counter; on reaching DB_CYCLES, go to IDLE, with GS=0 and L=0 from the next cycle.
REQ-025 RELEASE, any key active -> return to PRESSED with no event; GS stays 1.
REQ-026 GS SHALL be 1 in PRESSED and RELEASE and 0 in IDLE and DEBOUNCE; L SHALL be 0 whenever GS=0.
REQ-027 Latency: evt_valid SHALL rise exactly DB_CYCLES+2 clk edges after a stable S_n transition.
- 2 edges for the synchronizer plus DB_CYCLES edges for the debounce.
REQ-028 Posting an event SHALL set evt_valid=1 and load evt_code.
REQ-029 A handshake SHALL occur when evt_valid=1 and evt_ready=1 on the same edge; evt_valid SHALL then clear, unless a new event is posted on that same edge.
REQ-030 New event posted while evt_valid=1 and evt_ready=0: the event SHALL be dropped, evt_code retained, and ovf set.
REQ-031 New event coinciding with a handshake: the new event SHALL be loaded, evt_valid stays 1, and ovf is unchanged.
REQ-032 ovf SHALL be sticky; ovf_clr=1 SHALL clear it, and a simultaneous overflow SHALL take priority (ovf=1).
REQ-033 The debounce counter SHALL be $clog2(DB_CYCLES+1) bits wide and SHALL never wrap; its reload values SHALL be exactly as stated above.
REQ-034 evt_ready asserted while evt_valid=0 SHALL have no effect.

Reset
REQ-035 rst=1 SHALL asynchronously force: synchronizer flops to all-ones, FSM to IDLE, counter=0, L=0, GS=0, evt_valid=0, evt_code=0, ovf=0.
REQ-036 Reset asserted mid-debounce or mid-press SHALL abandon the pending event with no event posted.
- After release of reset, a still-held key SHALL need a full DB_CYCLES to be debounced again.

Verification (N_KEYS=10, DB_CYCLES=4)
REQ-037 Press and hold key 5, evt_ready=0 -> evt_valid=1 and evt_code=5 on edge 6; GS=1 and L=5 from then on.
REQ-038 Key 5 glitches low for 2 cycles, then high -> no event, GS stays 0 throughout.
REQ-039 Keys 9 and 2 pressed together and held -> one event with code 9; then releasing key 9 while holding key 2 -> no new event, L stays 9.
REQ-040 Key 3 held then released, with a 2-cycle re-bounce during RELEASE -> returns to PRESSED, GS never drops, no second event.
REQ-041 Two separate debounced presses, 7 then 1, with evt_ready=0 -> evt_code stays 7 and ovf=1; then ovf_clr=1 -> ovf=0.
REQ-042 rst pulsed while key 4 is held in PRESSED -> all outputs 0 immediately; with the key still held, evt_valid re-rises 6 edges after rst deasserts.
